// File: rtl/mcs8_pkg.sv
// Shared MCS8 definitions: PC-stack operation encodings and widths
// used by the program-counter block and its return stack.
package mcs8_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INC  = 3'd1,
    OP_LDL  = 3'd2,
    OP_LDH  = 3'd3,
    OP_JMP  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RST  = 3'd7
  } op_e;

  localparam int RST_SHIFT = 3;
  localparam int CNT_W     = 5;

endpackage

// File: rtl/cpu_pcstack_if.sv
// Sequencer-to-PC-stack bundle: operation request in, PC and stack status out.
interface cpu_pcstack_if #(
  parameter int ADDR_W = 14
);
  import mcs8_pkg::*;

  logic [2:0]        OP_I;
  logic              COND_I;
  logic [7:0]        DATA_I;
  logic              HI_I;
  logic              CLR_ERR_I;
  logic [ADDR_W-1:0] PC_O;
  logic [7:0]        PCB_O;
  logic [CNT_W-1:0]  CNT_O;
  logic              FULL_O;
  logic              EMPTY_O;
  logic              OVF_O;
  logic              UNF_O;

  modport master (
    output OP_I, COND_I, DATA_I, HI_I, CLR_ERR_I,
    input  PC_O, PCB_O, CNT_O, FULL_O, EMPTY_O, OVF_O, UNF_O
  );

  modport slave (
    input  OP_I, COND_I, DATA_I, HI_I, CLR_ERR_I,
    output PC_O, PCB_O, CNT_O, FULL_O, EMPTY_O, OVF_O, UNF_O
  );
endinterface

// File: rtl/cpu_pcstack_mem.sv
// Circular return-address store: DEPTH entries, write pointer wraps modulo DEPTH,
// occupancy count saturates at 0 and DEPTH.
module cpu_pcstack_mem
  import mcs8_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 7,
  parameter int MODE_WRAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_wdata,
  output logic [ADDR_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_full,
  output logic              o_empty
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [CNT_W-1:0]  r_cnt;
  logic [PW-1:0]     w_wpInc;
  logic [PW-1:0]     w_wpDec;
  logic              w_doPush;
  logic              w_doPop;

  assign w_wpInc  = (r_wp == LAST) ? '0 : r_wp + PW'(1);
  assign w_wpDec  = (r_wp == '0) ? LAST : r_wp - PW'(1);
  assign o_rdata  = r_mem[w_wpDec];
  assign o_cnt    = r_cnt;
  assign o_full   = (r_cnt == CNT_W'(DEPTH));
  assign o_empty  = (r_cnt == '0);

  // In saturate mode a push on full or pop on empty leaves the store untouched
  assign w_doPush = i_push && (!o_full || (MODE_WRAP != 0));
  assign w_doPop  = i_pop && (!o_empty || (MODE_WRAP != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_doPush) begin
      r_mem[r_wp] <= i_wdata;
      r_wp        <= w_wpInc;
      if (!o_full) r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_doPop) begin
      r_wp <= w_wpDec;
      if (!o_empty) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_pcstack.sv
// MCS8 program counter with jump-target assembly, conditional jump/call/return,
// restart vectors and sticky overflow/underflow flags over a circular return stack.
module cpu_pcstack
  import mcs8_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 7,
  parameter int MODE_WRAP = 1
) (
  input  logic          CLK_I,
  input  logic          nRST_I,
  cpu_pcstack_if.slave  bus
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tgt;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] w_pcNext;
  logic [ADDR_W-1:0] w_tgtNext;
  logic [ADDR_W-1:0] w_rdata;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_popOk;

  cpu_pcstack_mem #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .MODE_WRAP(MODE_WRAP)
  ) u_mem (
    .clk    (CLK_I),
    .rst_n  (nRST_I),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(r_pc),
    .o_rdata(w_rdata),
    .o_cnt  (bus.CNT_O),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign w_popOk = !w_empty || (MODE_WRAP != 0);

  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_pcNext  = r_pc;
    w_tgtNext = r_tgt;
    case (bus.OP_I)
      OP_NOP: ;
      OP_INC: w_pcNext = r_pc + ADDR_W'(1);
      OP_LDL: w_tgtNext[7:0] = bus.DATA_I;
      OP_LDH: w_tgtNext[ADDR_W-1:8] = bus.DATA_I[ADDR_W-9:0];
      OP_JMP: if (bus.COND_I) w_pcNext = r_tgt;
      OP_CALL: begin
        if (bus.COND_I) begin
          w_push   = 1'b1;
          w_pcNext = r_tgt;
        end
      end
      OP_RET: begin
        if (bus.COND_I) begin
          w_pop = 1'b1;
          if (w_popOk) w_pcNext = w_rdata;
        end
      end
      OP_RST: begin
        w_push   = 1'b1;
        w_pcNext = ADDR_W'(bus.DATA_I[5:3]) << RST_SHIFT;
      end
    endcase
  end

  // A fresh error in the same cycle as a clear request keeps its flag set
  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      r_pc  <= '0;
      r_tgt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pcNext;
      r_tgt <= w_tgtNext;
      r_ovf <= (r_ovf && !bus.CLR_ERR_I) || (w_push && w_full);
      r_unf <= (r_unf && !bus.CLR_ERR_I) || (w_pop && w_empty);
    end
  end

  assign bus.PC_O    = r_pc;
  assign bus.PCB_O   = bus.HI_I ? 8'(r_pc >> 8) : r_pc[7:0];
  assign bus.FULL_O  = w_full;
  assign bus.EMPTY_O = w_empty;
  assign bus.OVF_O   = r_ovf;
  assign bus.UNF_O   = r_unf;

endmodule

// File: tb/tb_cpu_pcstack.sv
// Directed bench for cpu_pcstack: a wrapping and a saturating instance share
// the same stimulus so overflow/underflow behaviour can be compared side by side.
module tb_cpu_pcstack;
  import mcs8_pkg::*;

  logic       CLK_I = 1'b0;
  logic       nRST_I;
  logic [2:0] op;
  logic       cond;
  logic [7:0] data;
  logic       hi;
  logic       clrErr;
  int         nChecks;
  int         nFail;

  always #5 CLK_I = ~CLK_I;

  cpu_pcstack_if #(.ADDR_W(14)) busW ();
  cpu_pcstack_if #(.ADDR_W(14)) busS ();

  assign busW.OP_I      = op;
  assign busW.COND_I    = cond;
  assign busW.DATA_I    = data;
  assign busW.HI_I      = hi;
  assign busW.CLR_ERR_I = clrErr;
  assign busS.OP_I      = op;
  assign busS.COND_I    = cond;
  assign busS.DATA_I    = data;
  assign busS.HI_I      = hi;
  assign busS.CLR_ERR_I = clrErr;

  cpu_pcstack #(.ADDR_W(14), .DEPTH(7), .MODE_WRAP(1)) dutW (
    .CLK_I (CLK_I),
    .nRST_I(nRST_I),
    .bus   (busW.slave)
  );

  cpu_pcstack #(.ADDR_W(14), .DEPTH(7), .MODE_WRAP(0)) dutS (
    .CLK_I (CLK_I),
    .nRST_I(nRST_I),
    .bus   (busS.slave)
  );

  // One operation per clock; outputs are sampled 1 time unit after the edge
  task automatic doOp(input logic [2:0] o, input logic c, input logic [7:0] d);
    op   = o;
    cond = c;
    data = d;
    @(posedge CLK_I);
    #1;
    op   = OP_NOP;
    cond = 1'b0;
  endtask

  task automatic doReset();
    @(negedge CLK_I);
    nRST_I = 1'b0;
    #2;
    nRST_I = 1'b1;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic test_reset();
    @(posedge CLK_I);
    #1;
    nChecks++; if (busW.PC_O !== 14'h0000) begin nFail++; $display("[TB] FAIL reset_pc: got %h expected %h", busW.PC_O, 14'h0000); end
    nChecks++; if (busW.PCB_O !== 8'h00) begin nFail++; $display("[TB] FAIL reset_pcb: got %h expected %h", busW.PCB_O, 8'h00); end
    nChecks++; if (busW.CNT_O !== 5'd0) begin nFail++; $display("[TB] FAIL reset_cnt: got %0d expected %0d", busW.CNT_O, 0); end
    nChecks++; if (busW.EMPTY_O !== 1'b1) begin nFail++; $display("[TB] FAIL reset_empty: got %b expected %b", busW.EMPTY_O, 1'b1); end
    nChecks++; if (busW.FULL_O !== 1'b0) begin nFail++; $display("[TB] FAIL reset_full: got %b expected %b", busW.FULL_O, 1'b0); end
    nChecks++; if ({busW.OVF_O, busW.UNF_O} !== 2'b00) begin nFail++; $display("[TB] FAIL reset_flags: got %b expected %b", {busW.OVF_O, busW.UNF_O}, 2'b00); end
    nChecks++; if ({busS.PC_O, busS.CNT_O, busS.EMPTY_O, busS.FULL_O, busS.OVF_O, busS.UNF_O} !== {14'h0, 5'd0, 4'b1000}) begin
      nFail++; $display("[TB] FAIL reset_sat: got %h expected %h", {busS.PC_O, busS.CNT_O, busS.EMPTY_O, busS.FULL_O, busS.OVF_O, busS.UNF_O}, {14'h0, 5'd0, 4'b1000});
    end
    @(negedge CLK_I);
    nRST_I = 1'b1;
  endtask

  task automatic test_inc();
    hi = 1'b0;
    for (int i = 0; i < 3; i++) doOp(OP_INC, 1'b0, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h0003) begin nFail++; $display("[TB] FAIL inc_pc: got %h expected %h", busW.PC_O, 14'h0003); end
    nChecks++; if (busW.PCB_O !== 8'h03) begin nFail++; $display("[TB] FAIL inc_pcb: got %h expected %h", busW.PCB_O, 8'h03); end
    nChecks++; if (busW.EMPTY_O !== 1'b1) begin nFail++; $display("[TB] FAIL inc_empty: got %b expected %b", busW.EMPTY_O, 1'b1); end
    nChecks++; if (busS.PC_O !== 14'h0003) begin nFail++; $display("[TB] FAIL inc_pc_sat: got %h expected %h", busS.PC_O, 14'h0003); end
  endtask

  task automatic test_call_ret();
    doOp(OP_LDL, 1'b0, 8'h34);
    doOp(OP_LDH, 1'b0, 8'h12);
    nChecks++; if (busW.PC_O !== 14'h0003) begin nFail++; $display("[TB] FAIL ld_keeps_pc: got %h expected %h", busW.PC_O, 14'h0003); end
    doOp(OP_CALL, 1'b1, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h1234) begin nFail++; $display("[TB] FAIL call_pc: got %h expected %h", busW.PC_O, 14'h1234); end
    nChecks++; if (busW.CNT_O !== 5'd1) begin nFail++; $display("[TB] FAIL call_cnt: got %0d expected %0d", busW.CNT_O, 1); end
    nChecks++; if (busS.PC_O !== 14'h1234) begin nFail++; $display("[TB] FAIL call_pc_sat: got %h expected %h", busS.PC_O, 14'h1234); end
    hi = 1'b1;
    #1;
    nChecks++; if (busW.PCB_O !== 8'h12) begin nFail++; $display("[TB] FAIL pcb_high: got %h expected %h", busW.PCB_O, 8'h12); end
    hi = 1'b0;
    #1;
    nChecks++; if (busW.PCB_O !== 8'h34) begin nFail++; $display("[TB] FAIL pcb_low: got %h expected %h", busW.PCB_O, 8'h34); end
    doOp(OP_RET, 1'b1, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h0003) begin nFail++; $display("[TB] FAIL ret_pc: got %h expected %h", busW.PC_O, 14'h0003); end
    nChecks++; if (busW.CNT_O !== 5'd0) begin nFail++; $display("[TB] FAIL ret_cnt: got %0d expected %0d", busW.CNT_O, 0); end
    nChecks++; if (busS.PC_O !== 14'h0003) begin nFail++; $display("[TB] FAIL ret_pc_sat: got %h expected %h", busS.PC_O, 14'h0003); end
  endtask

  task automatic test_cond_rst();
    doOp(OP_JMP, 1'b0, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h0003) begin nFail++; $display("[TB] FAIL jmp_nt_pc: got %h expected %h", busW.PC_O, 14'h0003); end
    doOp(OP_CALL, 1'b0, 8'h00);
    nChecks++; if ({busW.PC_O, busW.CNT_O} !== {14'h0003, 5'd0}) begin nFail++; $display("[TB] FAIL call_nt: got %h expected %h", {busW.PC_O, busW.CNT_O}, {14'h0003, 5'd0}); end
    doOp(OP_RET, 1'b0, 8'h00);
    nChecks++; if ({busW.PC_O, busW.CNT_O, busW.UNF_O} !== {14'h0003, 5'd0, 1'b0}) begin nFail++; $display("[TB] FAIL ret_nt: got %h expected %h", {busW.PC_O, busW.CNT_O, busW.UNF_O}, {14'h0003, 5'd0, 1'b0}); end
    doOp(OP_RST, 1'b0, 8'h38);
    nChecks++; if (busW.PC_O !== 14'h0038) begin nFail++; $display("[TB] FAIL rst38_pc: got %h expected %h", busW.PC_O, 14'h0038); end
    nChecks++; if (busW.CNT_O !== 5'd1) begin nFail++; $display("[TB] FAIL rst38_cnt: got %0d expected %0d", busW.CNT_O, 1); end
    doOp(OP_RST, 1'b0, 8'hEA);
    nChecks++; if ({busW.PC_O, busW.CNT_O} !== {14'h0028, 5'd2}) begin nFail++; $display("[TB] FAIL rstEA: got %h expected %h", {busW.PC_O, busW.CNT_O}, {14'h0028, 5'd2}); end
    doOp(OP_RET, 1'b1, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h0038) begin nFail++; $display("[TB] FAIL rst_ret1: got %h expected %h", busW.PC_O, 14'h0038); end
    doOp(OP_RET, 1'b1, 8'h00);
    nChecks++; if ({busS.PC_O, busS.CNT_O} !== {14'h0003, 5'd0}) begin nFail++; $display("[TB] FAIL rst_ret2: got %h expected %h", {busS.PC_O, busS.CNT_O}, {14'h0003, 5'd0}); end
    doOp(OP_JMP, 1'b1, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h1234) begin nFail++; $display("[TB] FAIL jmp_t_pc: got %h expected %h", busW.PC_O, 14'h1234); end
  endtask

  task automatic test_overflow();
    doReset();
    for (int k = 1; k <= 8; k++) begin
      doOp(OP_LDL, 1'b0, 8'(k));
      doOp(OP_JMP, 1'b1, 8'h00);
      doOp(OP_LDL, 1'b0, 8'(8'h40 + k));
      doOp(OP_CALL, 1'b1, 8'h00);
      if (k == 7) begin
        nChecks++; if ({busW.CNT_O, busW.FULL_O, busW.OVF_O} !== {5'd7, 2'b10}) begin nFail++; $display("[TB] FAIL full_wrap: got %h expected %h", {busW.CNT_O, busW.FULL_O, busW.OVF_O}, {5'd7, 2'b10}); end
        nChecks++; if ({busS.CNT_O, busS.FULL_O, busS.OVF_O} !== {5'd7, 2'b10}) begin nFail++; $display("[TB] FAIL full_sat: got %h expected %h", {busS.CNT_O, busS.FULL_O, busS.OVF_O}, {5'd7, 2'b10}); end
      end
    end
    nChecks++; if ({busW.PC_O, busW.CNT_O, busW.OVF_O} !== {14'h0048, 5'd7, 1'b1}) begin nFail++; $display("[TB] FAIL ovf_wrap: got %h expected %h", {busW.PC_O, busW.CNT_O, busW.OVF_O}, {14'h0048, 5'd7, 1'b1}); end
    nChecks++; if ({busS.PC_O, busS.CNT_O, busS.OVF_O} !== {14'h0048, 5'd7, 1'b1}) begin nFail++; $display("[TB] FAIL ovf_sat: got %h expected %h", {busS.PC_O, busS.CNT_O, busS.OVF_O}, {14'h0048, 5'd7, 1'b1}); end
  endtask

  task automatic test_underflow();
    for (int i = 1; i <= 7; i++) begin
      doOp(OP_RET, 1'b1, 8'h00);
      nChecks++; if (busW.PC_O !== 14'(9 - i)) begin nFail++; $display("[TB] FAIL pop_wrap_%0d: got %h expected %h", i, busW.PC_O, 14'(9 - i)); end
      nChecks++; if (busS.PC_O !== 14'(8 - i)) begin nFail++; $display("[TB] FAIL pop_sat_%0d: got %h expected %h", i, busS.PC_O, 14'(8 - i)); end
    end
    nChecks++; if ({busW.CNT_O, busW.EMPTY_O, busW.UNF_O} !== {5'd0, 2'b10}) begin nFail++; $display("[TB] FAIL drained_wrap: got %h expected %h", {busW.CNT_O, busW.EMPTY_O, busW.UNF_O}, {5'd0, 2'b10}); end
    doOp(OP_RET, 1'b1, 8'h00);
    nChecks++; if ({busW.PC_O, busW.CNT_O, busW.UNF_O} !== {14'h0008, 5'd0, 1'b1}) begin nFail++; $display("[TB] FAIL unf_wrap: got %h expected %h", {busW.PC_O, busW.CNT_O, busW.UNF_O}, {14'h0008, 5'd0, 1'b1}); end
    nChecks++; if ({busS.PC_O, busS.CNT_O, busS.UNF_O} !== {14'h0001, 5'd0, 1'b1}) begin nFail++; $display("[TB] FAIL unf_sat: got %h expected %h", {busS.PC_O, busS.CNT_O, busS.UNF_O}, {14'h0001, 5'd0, 1'b1}); end
  endtask

  task automatic test_clear_err();
    clrErr = 1'b1;
    doOp(OP_RET, 1'b1, 8'h00);
    clrErr = 1'b0;
    nChecks++; if ({busW.OVF_O, busW.UNF_O} !== 2'b01) begin nFail++; $display("[TB] FAIL clr_vs_err_wrap: got %b expected %b", {busW.OVF_O, busW.UNF_O}, 2'b01); end
    nChecks++; if ({busS.OVF_O, busS.UNF_O} !== 2'b01) begin nFail++; $display("[TB] FAIL clr_vs_err_sat: got %b expected %b", {busS.OVF_O, busS.UNF_O}, 2'b01); end
    clrErr = 1'b1;
    doOp(OP_NOP, 1'b0, 8'h00);
    clrErr = 1'b0;
    nChecks++; if ({busW.OVF_O, busW.UNF_O, busS.OVF_O, busS.UNF_O} !== 4'b0000) begin nFail++; $display("[TB] FAIL clr_flags: got %b expected %b", {busW.OVF_O, busW.UNF_O, busS.OVF_O, busS.UNF_O}, 4'b0000); end
  endtask

  task automatic test_async_reset();
    doReset();
    doOp(OP_LDL, 1'b0, 8'h21);
    doOp(OP_LDH, 1'b0, 8'h05);
    for (int i = 0; i < 3; i++) doOp(OP_CALL, 1'b1, 8'h00);
    nChecks++; if ({busW.PC_O, busW.CNT_O} !== {14'h0521, 5'd3}) begin nFail++; $display("[TB] FAIL pre_reset: got %h expected %h", {busW.PC_O, busW.CNT_O}, {14'h0521, 5'd3}); end
    #2;
    nRST_I = 1'b0;
    #2;
    nChecks++; if ({busW.PC_O, busW.PCB_O, busW.CNT_O, busW.EMPTY_O, busW.FULL_O, busW.OVF_O, busW.UNF_O} !== {14'h0, 8'h0, 5'd0, 4'b1000}) begin
      nFail++; $display("[TB] FAIL async_reset_wrap: got %h expected %h", {busW.PC_O, busW.PCB_O, busW.CNT_O, busW.EMPTY_O, busW.FULL_O, busW.OVF_O, busW.UNF_O}, {14'h0, 8'h0, 5'd0, 4'b1000});
    end
    nChecks++; if ({busS.PC_O, busS.CNT_O, busS.EMPTY_O} !== {14'h0, 5'd0, 1'b1}) begin nFail++; $display("[TB] FAIL async_reset_sat: got %h expected %h", {busS.PC_O, busS.CNT_O, busS.EMPTY_O}, {14'h0, 5'd0, 1'b1}); end
    @(negedge CLK_I);
    nRST_I = 1'b1;
    doOp(OP_INC, 1'b0, 8'h00);
    doOp(OP_JMP, 1'b1, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h0000) begin nFail++; $display("[TB] FAIL tgt_cleared: got %h expected %h", busW.PC_O, 14'h0000); end
  endtask

  task automatic test_inc_wrap();
    doOp(OP_LDL, 1'b0, 8'hFF);
    doOp(OP_LDH, 1'b0, 8'hFF);
    doOp(OP_JMP, 1'b1, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h3FFF) begin nFail++; $display("[TB] FAIL ldh_mask: got %h expected %h", busW.PC_O, 14'h3FFF); end
    hi = 1'b1;
    #1;
    nChecks++; if (busW.PCB_O !== 8'h3F) begin nFail++; $display("[TB] FAIL pcb_zext: got %h expected %h", busW.PCB_O, 8'h3F); end
    hi = 1'b0;
    doOp(OP_INC, 1'b0, 8'h00);
    nChecks++; if (busW.PC_O !== 14'h0000) begin nFail++; $display("[TB] FAIL inc_wrap: got %h expected %h", busW.PC_O, 14'h0000); end
  endtask

  task automatic test_back_to_back();
    doOp(OP_LDL, 1'b0, 8'h10);
    doOp(OP_CALL, 1'b1, 8'h00);
    doOp(OP_CALL, 1'b1, 8'h00);
    doOp(OP_RET, 1'b1, 8'h00);
    nChecks++; if ({busW.PC_O, busW.CNT_O} !== {14'h3F10, 5'd1}) begin nFail++; $display("[TB] FAIL b2b_ret1: got %h expected %h", {busW.PC_O, busW.CNT_O}, {14'h3F10, 5'd1}); end
    doOp(OP_CALL, 1'b1, 8'h00);
    doOp(OP_RET, 1'b1, 8'h00);
    nChecks++; if ({busW.PC_O, busW.CNT_O} !== {14'h3F10, 5'd1}) begin nFail++; $display("[TB] FAIL b2b_ret2: got %h expected %h", {busW.PC_O, busW.CNT_O}, {14'h3F10, 5'd1}); end
    doOp(OP_RET, 1'b1, 8'h00);
    nChecks++; if ({busS.PC_O, busS.CNT_O, busS.EMPTY_O} !== {14'h0000, 5'd0, 1'b1}) begin nFail++; $display("[TB] FAIL b2b_ret3: got %h expected %h", {busS.PC_O, busS.CNT_O, busS.EMPTY_O}, {14'h0000, 5'd0, 1'b1}); end
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    nRST_I  = 1'b0;
    op      = OP_NOP;
    cond    = 1'b0;
    data    = 8'h00;
    hi      = 1'b0;
    clrErr  = 1'b0;
    test_reset();
    test_inc();
    test_call_ret();
    test_cond_rst();
    test_overflow();
    test_underflow();
    test_clear_err();
    test_async_reset();
    test_inc_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/cpu_pcstack.md
# cpu_pcstack

Parametrised program-counter and return-address stack for the MCS8 CPU family. Holds the active PC, assembles 2-byte jump/call targets from the data bus, and performs conditional jump/call/return and restart operations against a circular return stack. Supersedes the fixed 8-level, 14-bit stack array embedded in the CPU top. Adds selectable wrap/saturate overflow behaviour and sticky error flags. Driven once per operation by the CPU state sequencer.

## Interface
- ADDR_W, 14, PC and stack entry width; legal range 9..16.
- DEPTH, 7, return-address entries (nesting levels); legal range 2..16, need not be a power of 2.
- MODE_WRAP, 1, 1 = circular 8008 behaviour on overflow/underflow; 0 = saturate (refuse push/pop).
- CLK_I  in  1  single clock, all state updates on rising edge.
- nRST_I  in  1  asynchronous, active-low reset.
- OP_I  in  3  operation: 0 NOP, 1 INC, 2 LDL, 3 LDH, 4 JMP, 5 CALL, 6 RET, 7 RST.
- COND_I  in  1  condition qualifier for JMP/CALL/RET (1 = taken).
- DATA_I  in  8  target byte for LDL/LDH; vector source for RST.
- HI_I  in  1  byte select for PCB_O (0 = low byte, 1 = high byte).
- CLR_ERR_I  in  1  clears OVF_O/UNF_O.
- PC_O  out  ADDR_W  current PC.
- PCB_O  out  8  selected PC byte for bus out; high byte zero-extended.
- CNT_O  out  5  valid entries, 0..DEPTH.
- FULL_O  out  1  CNT_O == DEPTH.
- EMPTY_O  out  1  CNT_O == 0.
- OVF_O  out  1  sticky: push attempted while full.
- UNF_O  out  1  sticky: pop attempted while empty.

## Operation
- INC: PC <= PC+1 modulo 2^ADDR_W (0x3FFF -> 0x0000 at default).
- LDL: TGT[7:0] <= DATA_I. LDH: TGT[ADDR_W-1:8] <= DATA_I[ADDR_W-9:0]; upper DATA_I bits ignored. PC unchanged.
- JMP: COND_I=1 -> PC <= TGT; COND_I=0 -> no change.
- CALL: COND_I=1 -> push PC, PC <= TGT; COND_I=0 -> no change.
- RET: COND_I=1 -> pop into PC; COND_I=0 -> no change.
- RST: unconditional; push PC, PC <= {0, DATA_I[5:3], 3'b000}.
- TGT persists across ops; only LDL/LDH modify it.
- Storage: circular buffer, write pointer WP in 0..DEPTH-1. Push writes mem[WP], WP <= (WP+1) mod DEPTH. Pop reads mem[(WP-1) mod DEPTH], WP decrements mod DEPTH.
- Push while full: OVF_O set. WRAP: write proceeds, oldest entry overwritten, CNT stays DEPTH. SAT: no write, WP/CNT unchanged; PC still loads target.
- Pop while empty: UNF_O set. WRAP: stale slot popped into PC, WP decrements, CNT stays 0. SAT: PC, WP, CNT unchanged.
- CLR_ERR_I clears both flags; a new error in the same cycle wins (flag set).

## Timing
- All ops take effect on the CLK_I edge where OP_I is sampled; PC_O, CNT_O and flags are valid the next cycle; no multi-cycle ops, no handshake; one op per cycle.
- PCB_O, FULL_O, EMPTY_O are combinational from registered state and HI_I.
- Back-to-back CALL/RET legal; RET directly after CALL returns the pushed PC.
- Reset (any time, including mid-sequence): PC_O=0, TGT=0, WP=0, CNT_O=0, all mem entries 0, OVF_O=0, UNF_O=0; hence PCB_O=0, EMPTY_O=1, FULL_O=0.

## Structure
- Shared package mcs8_pkg: op encodings (OP_NOP..OP_RST), RST vector shift (3), CNT_O width constant.
- One sub-module cpu_pcstack_mem: DEPTH x ADDR_W register file with WP, push/pop/wrap logic, CNT and full/empty; top holds PC, TGT, op decode and flags.

## Test plan
- Reset, then 3x INC, HI_I=0 -> PC_O=0x0003, PCB_O=0x03, EMPTY_O=1.
- LDL 0x34, LDH 0x12, CALL COND=1 from PC 0x0003 -> PC_O=0x1234, CNT_O=1; RET COND=1 -> PC_O=0x0003, CNT_O=0; HI_I=1 at 0x1234 -> PCB_O=0x12.
- JMP/CALL/RET with COND_I=0 -> PC_O, CNT_O unchanged; RST DATA_I=0x38 -> PC_O=0x0038, CNT_O=1.
- MODE_WRAP=1: 8 CALLs pushing 1..8 -> OVF_O=1, CNT_O=7; 7 RETs return 8..2; 8th RET -> UNF_O=1, PC_O=8 (stale slot).
- MODE_WRAP=0: 8th CALL -> OVF_O=1, PC_O=target, CNT_O=7; RET at CNT_O=0 -> UNF_O=1, PC_O unchanged; CLR_ERR_I -> flags 0.
- Assert nRST_I asynchronously mid-CALL sequence at CNT_O=3 -> all outputs at reset values before next edge; INC at PC 0x3FFF -> 0x0000.
